rgb_stream_packer: RTL
======================

Name: rgb_stream_packer

Overview:
- Receiver end of the colour-serial pixel stream that denoise and the other ISP stages emit: one colour component per beat, tagged RED/GREEN/BLUE, with a last-column flag.
- Packs each R, G, B triple into one 24-bit RGB word and buffers it in a small FIFO.
- Presents the word on a valid/ready interface for downstream consumers (frame writer, colour-space converter).
- Detects protocol errors and overflow, since the serial stream has no backpressure.

Parameters:
- COLOR_DEPTH, 8, bits per colour component.
- FIFO_DEPTH, 4, packed-pixel FIFO entries; must be a power of 2 and ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- pixel_in  in  COLOR_DEPTH  colour component value.
- valid_in  in  1  beat qualifier.
- color_in  in  3  component tag: 0=RED, 1=GREEN, 2=BLUE, 3=VOID; any other value is treated as VOID.
- last_col_in  in  1  last-pixel flag; sampled only on the BLUE beat.
- ready_in  in  1  downstream accepts rgb_out this cycle.
- rgb_out  out  3*COLOR_DEPTH  packed pixel {R,G,B}, R in the MSBs.
- valid_out  out  1  FIFO non-empty.
- last_out  out  1  last flag of the word on rgb_out.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy.
- proto_err  out  1  sticky; colour sequence violation.
- overflow  out  1  sticky; pixel dropped because the FIFO was full.
- clear_err  in  1  synchronously clears proto_err and overflow.

Behaviour:
- Reset values:
  - outputs: rgb_out=0, valid_out=0, last_out=0, fifo_count=0, proto_err=0, overflow=0.
  - internal: FSM=EXP_R, FIFO empty, R/G holding registers=0.
- Beats with valid_in=0 are ignored entirely; the FSM holds state.
- FSM states EXP_R, EXP_G, EXP_B:
  - EXP_R + RED: capture R, go to EXP_G.
  - EXP_G + GREEN: capture G, go to EXP_B.
  - EXP_B + BLUE: push {R,G,pixel_in} with last_col_in into the FIFO, go to EXP_R.
  - Any other tag (wrong colour or VOID): set proto_err and discard the beat and any partial pixel.
    - If the offending tag is RED, capture it as a new R and go to EXP_G (resync).
    - Otherwise go to EXP_R.
- FIFO is first-word-fall-through:
  - rgb_out and last_out show the head entry; valid_out = (fifo_count≠0).
  - Pop occurs when valid_out && ready_in.
- Latency: BLUE beat accepted at edge t → valid_out=1 and word visible after edge t+1 (one cycle), provided the FIFO was empty.
- Push while full:
  - If a pop occurs in the same cycle, the push succeeds and count is unchanged.
  - Otherwise the pixel is dropped, overflow is set, and the FSM still returns to EXP_R.
- Push on empty with ready_in=1: the word appears next cycle; there is no bypass.
- Output stability: rgb_out and last_out are stable while valid_out && !ready_in.
- Pointers wrap modulo FIFO_DEPTH; fifo_count saturates at neither end because it is guarded.
- Error flags: if clear_err coincides with a new error, the error wins (flag stays 1).
- Reset mid-pixel or mid-drain: FIFO contents and partial pixel are discarded and the FSM returns to EXP_R. Beats arriving after reset are decoded from EXP_R, so a trailing G/B raises proto_err.
- The last flag is not checked for position; it is passed through as received.

Decomposition:
- Package isp_pkg:
  - colour codes RED/GREEN/BLUE/VOID (2'd0..3, zero-extended to 3 bits);
  - FSM state enum;
  - COLOR_DEPTH default.
- Sub-module pixel_fifo: synchronous FWFT FIFO, parameters WIDTH=3*COLOR_DEPTH+1 and DEPTH. Ports push/din/full/pop/dout/empty/count.
- The top level holds the FSM, holding registers and error flags.

Test Plan:
- Single pixel: R=0x12, G=0x34, B=0x56, ready_in=1 → one cycle after the B beat, valid_out=1 for one cycle with rgb_out=0x123456, last_out=0; no error flags.
- Backpressure: ready_in=0, send 5 pixels (0x010203…0x0D0E0F) → fifo_count=4 and overflow=1 after the 5th. Then ready_in=1 → 4 words drain in order, 5th absent, fifo_count returns to 0.
- Full with simultaneous push/pop: FIFO full, ready_in=1 on the cycle of a B beat → no overflow, fifo_count stays 4, order preserved.
- Sequence errors:
  - R=0xAA, B=0xBB → proto_err=1, no output.
  - Then R=0x11, G=0x22, B=0x33 → rgb_out=0x112233.
  - R, G, RED(0x44), G=0x55, B=0x66 → proto_err=1, output 0x445566 (resync).
  - VOID after R → proto_err=1.
  - clear_err pulse → flags return to 0.
- Last flag: 3 pixels, last_col_in=1 only on the 3rd pixel's beats → last_out=1 only with the 3rd word.
- Reset mid-operation:
  - Send R, G, assert rst one cycle, then G, B → no output, proto_err=1.
  - Reset during a 3-entry backlog → valid_out=0 and fifo_count=0 next cycle.

Source files
------------

// File: rtl/isp_pkg.sv
// Shared definitions for the ISP colour-serial stream: component tags,
// packer FSM states and the default component width.
package isp_pkg;

   localparam int unsigned DEFAULT_COLOR_DEPTH = 8;

   localparam logic [2:0] RED   = 3'd0;
   localparam logic [2:0] GREEN = 3'd1;
   localparam logic [2:0] BLUE  = 3'd2;
   localparam logic [2:0] VOID  = 3'd3;

   typedef enum logic [1:0] {
      EXP_R,
      EXP_G,
      EXP_B
   } pack_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous first-word-fall-through FIFO for packed pixels. dout reads
// as zero while empty; a push into a full FIFO succeeds only alongside a pop.
module pixel_fifo #(
   parameter int unsigned WIDTH = 25,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   output logic                     full,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             wr_en;
   logic             rd_en;

   assign empty = (count == '0);
   assign full  = (count == FULL_CNT);
   assign rd_en = pop && !empty;
   assign wr_en = push && (!full || rd_en);
   assign dout  = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({wr_en, rd_en})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/rgb_stream_packer.sv
// Packs a colour-serial R/G/B component stream into {R,G,B} words buffered
// in a FWFT FIFO, flagging sequence violations and overflow drops.
module rgb_stream_packer
   import isp_pkg::*;
#(
   parameter int unsigned COLOR_DEPTH = DEFAULT_COLOR_DEPTH,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [COLOR_DEPTH-1:0]        pixel_in,
   input  logic                          valid_in,
   input  logic [2:0]                    color_in,
   input  logic                          last_col_in,
   input  logic                          ready_in,
   output logic [3*COLOR_DEPTH-1:0]      rgb_out,
   output logic                          valid_out,
   output logic                          last_out,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          proto_err,
   output logic                          overflow,
   input  logic                          clear_err
);

   localparam int unsigned WORD_W = 3*COLOR_DEPTH + 1;

   pack_state_t              state;
   pack_state_t              next_state;
   logic [COLOR_DEPTH-1:0]   r_hold;
   logic [COLOR_DEPTH-1:0]   g_hold;
   logic                     cap_r;
   logic                     cap_g;
   logic                     push_pix;
   logic                     seq_err;

   logic                     stage_vld;
   logic [WORD_W-1:0]        stage_word;
   logic [WORD_W-1:0]        head_word;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic                     pop;
   logic                     drop;

   always_comb begin
      next_state = state;
      cap_r      = 1'b0;
      cap_g      = 1'b0;
      push_pix   = 1'b0;
      seq_err    = 1'b0;
      if (valid_in) begin
         case (state)
            EXP_R: begin
               if (color_in == RED) begin
                  cap_r      = 1'b1;
                  next_state = EXP_G;
               end else begin
                  seq_err    = 1'b1;
                  next_state = EXP_R;
               end
            end
            EXP_G: begin
               if (color_in == GREEN) begin
                  cap_g      = 1'b1;
                  next_state = EXP_B;
               end else if (color_in == RED) begin
                  seq_err    = 1'b1;
                  cap_r      = 1'b1;
                  next_state = EXP_G;
               end else begin
                  seq_err    = 1'b1;
                  next_state = EXP_R;
               end
            end
            EXP_B: begin
               if (color_in == BLUE) begin
                  push_pix   = 1'b1;
                  next_state = EXP_R;
               end else if (color_in == RED) begin
                  seq_err    = 1'b1;
                  cap_r      = 1'b1;
                  next_state = EXP_G;
               end else begin
                  seq_err    = 1'b1;
                  next_state = EXP_R;
               end
            end
            default: next_state = EXP_R;
         endcase
      end
   end

   // Completed pixels pass through one staging register before the FIFO,
   // giving a fixed one-cycle latency from the BLUE beat to the FIFO write.
   assign pop  = valid_out && ready_in;
   assign drop = stage_vld && fifo_full && !pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= EXP_R;
         r_hold     <= '0;
         g_hold     <= '0;
         stage_vld  <= 1'b0;
         stage_word <= '0;
         proto_err  <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         state     <= next_state;
         stage_vld <= push_pix;
         if (cap_r) begin
            r_hold <= pixel_in;
         end
         if (cap_g) begin
            g_hold <= pixel_in;
         end
         if (push_pix) begin
            stage_word <= {r_hold, g_hold, pixel_in, last_col_in};
         end
         if (seq_err) begin
            proto_err <= 1'b1;
         end else if (clear_err) begin
            proto_err <= 1'b0;
         end
         if (drop) begin
            overflow <= 1'b1;
         end else if (clear_err) begin
            overflow <= 1'b0;
         end
      end
   end

   pixel_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (stage_vld),
      .din   (stage_word),
      .full  (fifo_full),
      .pop   (pop),
      .dout  (head_word),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign valid_out = !fifo_empty;
   assign rgb_out   = head_word[WORD_W-1:1];
   assign last_out  = head_word[0];

endmodule
